// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem request, one-entry hold buffer, IF/ID register.
// Optional stall counter port `stall_cycles` enabled by defining IF_STALL_CNT_EN.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        if_id_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid
`ifdef IF_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      KILL  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_nxt;
   logic [31:0] redirect_pc;
   logic [31:0] redirect_pc_nxt;
   logic [31:0] id_pc_nxt;
   logic [31:0] id_instr_nxt;
   logic        id_valid_nxt;

   logic        advance;
   logic [31:0] target;
   logic [31:0] pc_inc;

   assign advance = pc_write & if_id_write;
   assign target  = branch_target & ~32'h3;
   assign pc_inc  = pc + 32'd4;

   // KILL keeps the stale request alive so the handshake stays intact.
   assign imem_req  = rst_n & (state != HOLD);
   assign imem_addr = pc;

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      hold_instr_nxt  = hold_instr;
      redirect_pc_nxt = redirect_pc;
      id_pc_nxt       = id_pc;
      id_instr_nxt    = id_instr;
      id_valid_nxt    = id_valid;

      if (branch_taken) begin
         id_pc_nxt    = pc;
         id_instr_nxt = NOP_INSTR;
         id_valid_nxt = 1'b0;
         if (state != HOLD && !imem_ready) begin
            redirect_pc_nxt = target;
            state_nxt       = KILL;
         end else begin
            pc_nxt    = target;
            state_nxt = FETCH;
         end
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (advance) begin
                     id_pc_nxt    = pc;
                     id_instr_nxt = imem_rdata;
                     id_valid_nxt = 1'b1;
                     pc_nxt       = pc_inc;
                  end else begin
                     hold_instr_nxt = imem_rdata;
                     state_nxt      = HOLD;
                     if (if_id_write) begin
                        id_pc_nxt    = pc;
                        id_instr_nxt = NOP_INSTR;
                        id_valid_nxt = 1'b0;
                     end
                  end
               end else if (if_id_write) begin
                  id_pc_nxt    = pc;
                  id_instr_nxt = NOP_INSTR;
                  id_valid_nxt = 1'b0;
               end
            end
            HOLD: begin
               if (advance) begin
                  id_pc_nxt    = pc;
                  id_instr_nxt = hold_instr;
                  id_valid_nxt = 1'b1;
                  pc_nxt       = pc_inc;
                  state_nxt    = FETCH;
               end
            end
            KILL: begin
               id_pc_nxt    = pc;
               id_instr_nxt = NOP_INSTR;
               id_valid_nxt = 1'b0;
               if (imem_ready) begin
                  pc_nxt    = redirect_pc;
                  state_nxt = FETCH;
               end
            end
            default: begin
               state_nxt = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         hold_instr  <= NOP_INSTR;
         redirect_pc <= RESET_PC;
         id_pc       <= 32'h0;
         id_instr    <= NOP_INSTR;
         id_valid    <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         hold_instr  <= hold_instr_nxt;
         redirect_pc <= redirect_pc_nxt;
         id_pc       <= id_pc_nxt;
         id_instr    <= id_instr_nxt;
         id_valid    <= id_valid_nxt;
      end
   end

`ifdef IF_STALL_CNT_EN
   // A branch redirects the PC even with pc_write low, so it is not a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= 32'h0;
      end else if (!pc_write && !branch_taken &&
                   stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a transaction-level fetch model.
// Also checks that every valid IF/ID instruction matches memory at its PC.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write;
   logic        if_id_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
`ifdef IF_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_stage #(
      .RESET_PC (RST_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_valid     (id_valid)
`ifdef IF_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // model: fetch outstanding unless an instruction is parked
   logic        m_rst;
   logic [31:0] m_pc;
   logic        m_held;
   logic [31:0] m_held_data;
   logic        m_kill;
   logic [31:0] m_kill_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic        m_id_valid;
   logic [31:0] m_stall;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_pc       = RST_PC;
      m_held     = 1'b0;
      m_kill     = 1'b0;
      m_kill_pc  = RST_PC;
      m_id_pc    = 32'h0;
      m_id_instr = NOP;
      m_id_valid = 1'b0;
      m_stall    = 32'h0;
   endtask

   task automatic bubble();
      m_id_pc    = m_pc;
      m_id_instr = NOP;
      m_id_valid = 1'b0;
   endtask

   task automatic deliver(input logic [31:0] d);
      m_id_pc    = m_pc;
      m_id_instr = d;
      m_id_valid = 1'b1;
      m_pc       = m_pc + 32'd4;
   endtask

   task automatic step(input logic r, input logic pw, input logic iw,
                       input logic br, input logic [31:0] tg,
                       input logic rdy);
      logic busy;
      @(negedge clk);
      check("imem_req", {31'b0, imem_req}, {31'b0, m_rst & ~m_held});
      if (m_rst) check("imem_addr", imem_addr, m_pc);
      check("id_pc", id_pc, m_id_pc);
      check("id_instr", id_instr, m_id_instr);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
`ifdef IF_STALL_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif
      if (id_valid) check("stream", id_instr, mem(id_pc));

      rst_n         = r;
      pc_write      = pw;
      if_id_write   = iw;
      branch_taken  = br;
      branch_target = tg;
      imem_ready    = rdy;
      imem_rdata    = rdy ? mem(imem_addr) : 32'hDEAD_BEEF;
      m_rst         = r;

      if (!r) begin
         model_reset();
      end else begin
         busy = ~m_held;
         if (!pw && !br && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (br) begin
            bubble();
            m_held = 1'b0;
            if (busy && !rdy) begin
               m_kill    = 1'b1;
               m_kill_pc = tg & ~32'h3;
            end else begin
               m_kill = 1'b0;
               m_pc   = tg & ~32'h3;
            end
         end else if (m_kill) begin
            bubble();
            if (rdy) begin
               m_kill = 1'b0;
               m_pc   = m_kill_pc;
            end
         end else if (m_held) begin
            if (pw && iw) begin
               deliver(m_held_data);
               m_held = 1'b0;
            end
         end else if (rdy && pw && iw) begin
            deliver(mem(m_pc));
         end else if (rdy) begin
            m_held      = 1'b1;
            m_held_data = mem(m_pc);
            if (iw) bubble();
         end else if (iw) begin
            bubble();
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 1, 0, 0, 1);
   endtask

   initial begin
      rst_n         = 1'b0;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ready    = 1'b0;
      imem_rdata    = 32'h0;
      m_rst         = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // zero-wait streaming from reset
      step(0, 1, 1, 0, 0, 1);
      run(20);

      // stall with data ready at pc 0x8
      step(0, 1, 1, 0, 0, 1);
      run(2);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0, 0);
      run(4);

      // three wait states per fetch
      for (int i = 0; i < 4; i++) begin
         repeat (3) step(1, 1, 1, 0, 0, 0);
         step(1, 1, 1, 0, 0, 1);
      end

      // branch during a pending fetch at 0x10
      step(0, 1, 1, 0, 0, 1);
      run(4);
      step(1, 1, 1, 1, 32'h103, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      run(4);

      // branch with pc_write low
      step(1, 0, 0, 1, 32'h200, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      run(3);

      // reset while holding
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      run(4);

      // PC wrap
      step(1, 1, 1, 1, 32'hFFFF_FFF8, 1);
      run(4);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(199) != 0,
              $urandom_range(4) != 0,
              $urandom_range(4) != 0,
              $urandom_range(11) == 0,
              $urandom,
              $urandom_range(9) < 6);
      end
      step(1, 1, 1, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the program counter, drives the instruction-memory request, and writes the IF/ID pipeline register. Its inputs are the PC-write and IF/ID-write enables from the hazard detection unit and the branch redirect from EX. Its outputs are the instruction, PC and valid bit consumed by decode. A one-entry hold buffer prevents a returned instruction from being lost while decode is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `NOP_INSTR`, default 32'h0000_0013: encoding placed in IF/ID on bubble or flush (`addi x0,x0,0`).
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `pc_write` in 1: hazard unit PC-write enable; 0 = freeze PC.
- `if_id_write` in 1: hazard unit IF/ID-write enable; 0 = hold IF/ID.
- `branch_taken` in 1: EX redirect strobe, one cycle.
- `branch_target` in 32: redirect address; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_ready` in 1: memory response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction, valid when `imem_ready`.
- `id_pc` out 32: IF/ID PC.
- `id_instr` out 32: IF/ID instruction.
- `id_valid` out 1: IF/ID holds a real instruction.
- `stall_cycles` out 32: stall counter. Present only with `IF_STALL_CNT_EN`.

## Operation
- Registers: `pc`, `state` ∈ {FETCH, HOLD, KILL}, `hold_instr`, `redirect_pc`, IF/ID (`id_pc`/`id_instr`/`id_valid`).
- Memory protocol: once raised, `imem_req` and `imem_addr` stay stable until `imem_ready`. The address is always `pc`.
- "Advance" means `pc_write & if_id_write`.
- FETCH: `imem_req`=1.
  - `imem_ready` & advance: IF/ID ← {pc, rdata, 1}; pc ← pc+4.
  - `imem_ready` & !advance: `hold_instr` ← rdata; go HOLD.
  - !`imem_ready` & `if_id_write`: IF/ID ← bubble {pc, NOP_INSTR, 0}.
  - !`imem_ready` & !`if_id_write`: IF/ID holds.
- HOLD: `imem_req`=0.
  - On advance: IF/ID ← {pc, hold_instr, 1}; pc ← pc+4; go FETCH.
  - Otherwise hold.
- KILL: `imem_req`=1 to the stale address.
  - On `imem_ready`: discard the data; pc ← redirect_pc; go FETCH.
  - IF/ID loads a bubble while in KILL, regardless of `if_id_write`.
- `branch_taken` takes priority over everything.
  - IF/ID is flushed to a bubble.
  - Any held instruction is dropped.
  - If in FETCH with the request not completing this cycle: redirect_pc ← target; go KILL.
  - Otherwise (HOLD, or FETCH with `imem_ready`=1): pc ← target; go FETCH.
  - In KILL: redirect_pc is overwritten with the new target.
- `branch_taken` together with `pc_write`=0: the branch wins, and the PC is redirected anyway.

## Timing
- Reset (`rst_n`=0 at a clock edge) produces:
  - pc=RESET_PC, state=FETCH
  - id_pc=0, id_instr=NOP_INSTR, id_valid=0
  - stall_cycles=0
- `imem_req` is forced to 0 while `rst_n`=0. In the first cycle after reset, `imem_req`=1 and `imem_addr`=RESET_PC.
- Reset mid-operation discards any HOLD/KILL state with no memory handshake. The memory must accept an abandoned request.
- Latency: with zero-wait memory and no stalls, an instruction appears in IF/ID one edge after its address is presented. Throughput is 1 instruction per cycle.
- Redirect: the target is presented on `imem_addr` in the cycle after `branch_taken`, or after KILL completes. The minimum branch penalty is 2 bubbles.
- PC wrap: pc+4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).

## Configuration
- `IF_STALL_CNT_EN` defined:
  - `stall_cycles` increments, saturating at 0xFFFF_FFFF, on every cycle with `pc_write`=0 and `branch_taken`=0.
  - It is cleared by reset.
- Not defined: the port and the counter are absent, with no other behaviour change.

## Test plan
- Zero-wait memory (`imem_ready` tied 1), RESET_PC=0, no stalls:
  - `id_pc` sequences 0,4,8,…
  - `id_valid`=1 from the 2nd edge onward.
- Single-cycle stall while `imem_ready`=1 at pc=0x8:
  - Go HOLD; `imem_req`=0; IF/ID holds 0x4.
  - Next cycle, IF/ID = {0x8, rdata}, pc=0xC, no instruction lost or duplicated.
- 3-wait-state memory with `if_id_write`=1:
  - IF/ID carries 3 bubbles (`id_valid`=0, `id_instr`=0x00000013) between instructions.
- `branch_taken` with target 0x103 during a pending fetch at 0x10:
  - Go KILL; `imem_addr` stays 0x10 until ready; that data is dropped.
  - Next request addr=0x100; IF/ID is bubble throughout.
- `branch_taken` and `pc_write`=0 in the same cycle:
  - pc=target, IF/ID flushed.
  - With `IF_STALL_CNT_EN`, `stall_cycles` does not increment that cycle.
- Reset asserted while in HOLD:
  - Next cycle state=FETCH, `imem_addr`=RESET_PC, `id_valid`=0, `stall_cycles`=0.
